// File: rtl/irr_pkg.sv
// Shared definitions for the irrigation scheduler.
//   ch_state_e  : per-channel valve state (IDLE -> WATER -> SOAK)
//   DEF_*       : default parameter values used by the modules
//   popcount    : number of set bits in a vector (up to 32 bits)
package irr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATER = 2'd1,
    SOAK  = 2'd2
  } ch_state_e;

  localparam int DEF_N_CH         = 4;
  localparam int DEF_DW           = 8;
  localparam int DEF_TICK_DIV     = 16;
  localparam int DEF_MAX_ON_TICKS = 8;
  localparam int DEF_SOAK_TICKS   = 4;
  localparam int DEF_MAX_ACTIVE   = 2;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/irr_channel_fsm.sv
// One irrigation channel: hysteresis valve control with watering timeout,
// post-watering soak lockout and a sticky timeout fault.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : global enable; low sends the channel to IDLE
//   tick                : one-cycle timer tick from the shared prescaler
//   grant               : start permission from the arbiter (only honoured
//                         while request is high)
//   fault_clr           : clears the fault flag on the next edge
//   moist               : registered moisture value of this channel
//   low_thr, high_thr   : start / stop thresholds
//   state               : current state (ch_state_e encoding), also debug view
//   request             : channel wants to start watering this edge
//   leaving             : channel is in WATER and leaves it this edge
//   fault               : sticky timeout flag
module irr_channel_fsm
  import irr_pkg::*;
#(
  parameter int DW           = DEF_DW,
  parameter int MAX_ON_TICKS = DEF_MAX_ON_TICKS,
  parameter int SOAK_TICKS   = DEF_SOAK_TICKS,
  parameter int TMR_W        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          tick,
  input  logic          grant,
  input  logic          fault_clr,
  input  logic [DW-1:0] moist,
  input  logic [DW-1:0] low_thr,
  input  logic [DW-1:0] high_thr,
  output logic [1:0]    state,
  output logic          request,
  output logic          leaving,
  output logic          fault
);

  ch_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             fault_q, fault_d;
  logic             wet;
  logic             timeout;

  assign wet     = (moist >= high_thr);
  // Timeout is checked before the normal stop so it wins when both hold.
  assign timeout = (state_q == WATER) && tick &&
                   (timer_q == TMR_W'(MAX_ON_TICKS - 1));
  assign request = ena && (state_q == IDLE) && (moist < low_thr) && !fault_q;
  assign leaving = (state_q == WATER) && (!ena || timeout || wet);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fault_d = fault_q;
    if (fault_clr) begin
      fault_d = 1'b0;
    end
    if (!ena) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant && request) begin
            state_d = WATER;
            timer_d = '0;
          end
        end
        WATER: begin
          if (timeout) begin
            state_d = SOAK;
            timer_d = '0;
            fault_d = 1'b1;   // overrides a simultaneous fault_clr
          end else if (wet) begin
            state_d = SOAK;
            timer_d = '0;
          end else if (tick) begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        SOAK: begin
          if (tick) begin
            if (timer_q == TMR_W'(SOAK_TICKS - 1)) begin
              state_d = IDLE;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: rtl/irrigation_scheduler.sv
// N-channel irrigation controller.
// Holds the latest moisture sample per channel, a shared tick prescaler,
// one hysteresis FSM per channel and a start arbiter that limits how many
// valves are open at once.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   ena            : global enable; low forces every channel to IDLE
//   sample_valid   : sample strobe
//   sample_ch      : channel index of the sample (>= N_CH is ignored)
//   sample_data    : moisture value (higher = wetter)
//   low_thr        : start watering when moisture < low_thr
//   high_thr       : stop watering when moisture >= high_thr
//   fault_clr      : clears all fault flags on the next edge
//   valve          : valve drive per channel, 1 = open
//   fault          : sticky timeout flag per channel
//   active_cnt     : number of channels currently watering
//
// Handshake: a sample is accepted on every rising edge where sample_valid
// is high; there is no backpressure, so the source never waits.
module irrigation_scheduler
  import irr_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int DW           = DEF_DW,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int MAX_ON_TICKS = DEF_MAX_ON_TICKS,
  parameter int SOAK_TICKS   = DEF_SOAK_TICKS,
  parameter int MAX_ACTIVE   = DEF_MAX_ACTIVE,
  parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int CNT_W        = $clog2(N_CH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sample_valid,
  input  logic [CH_W-1:0]  sample_ch,
  input  logic [DW-1:0]    sample_data,
  input  logic [DW-1:0]    low_thr,
  input  logic [DW-1:0]    high_thr,
  input  logic             fault_clr,
  output logic [N_CH-1:0]  valve,
  output logic [N_CH-1:0]  fault,
  output logic [CNT_W-1:0] active_cnt
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int T_MAX = (MAX_ON_TICKS > SOAK_TICKS) ? MAX_ON_TICKS : SOAK_TICKS;
  localparam int TMR_W = $clog2(T_MAX + 1);

  logic [DW-1:0]    moist_q [N_CH];
  logic [PS_W-1:0]  presc_q;
  logic             tick;
  logic [1:0]       ch_state [N_CH];
  logic [N_CH-1:0]  request;
  logic [N_CH-1:0]  leaving;
  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  water;
  logic [N_CH-1:0]  staying;
  logic [N_CH-1:0]  water_next;
  logic [N_CH-1:0]  fault_w;
  logic [CNT_W-1:0] active_cnt_q;

  // Latest sample per channel. Indices with no matching channel simply
  // match nothing, which drops out-of-range samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        moist_q[i] <= '1;
      end
    end else if (sample_valid) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sample_ch == CH_W'(i)) begin
          moist_q[i] <= sample_data;
        end
      end
    end
  end

  // Free-running tick prescaler, independent of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (presc_q == PS_W'(TICK_DIV - 1)) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PS_W'(1);
    end
  end

  assign tick = (presc_q == PS_W'(TICK_DIV - 1));

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    irr_channel_fsm #(
      .DW           (DW),
      .MAX_ON_TICKS (MAX_ON_TICKS),
      .SOAK_TICKS   (SOAK_TICKS),
      .TMR_W        (TMR_W)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .tick      (tick),
      .grant     (grant[g]),
      .fault_clr (fault_clr),
      .moist     (moist_q[g]),
      .low_thr   (low_thr),
      .high_thr  (high_thr),
      .state     (ch_state[g]),
      .request   (request[g]),
      .leaving   (leaving[g]),
      .fault     (fault_w[g])
    );
    assign water[g] = (ch_state[g] == WATER);
  end

  // Channels that remain in WATER after this edge occupy slots; a channel
  // leaving this edge frees its slot for a requester on the same edge.
  assign staying = water & ~leaving;

  // Fixed-priority grant: lowest index first until the free slots run out.
  always_comb begin
    int slots;
    grant = '0;
    slots = MAX_ACTIVE - popcount(32'(staying));
    for (int i = 0; i < N_CH; i++) begin
      if (request[i] && (slots > 0)) begin
        grant[i] = 1'b1;
        slots    = slots - 1;
      end
    end
  end

  assign water_next = staying | grant;

  // Registered so it changes on the same edge as the valves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_cnt_q <= '0;
    end else begin
      active_cnt_q <= CNT_W'(popcount(32'(water_next)));
    end
  end

  assign valve      = water;
  assign fault      = fault_w;
  assign active_cnt = active_cnt_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
module tb_irrigation_scheduler;

  localparam int N_CH       = 5;
  localparam int DW         = 8;
  localparam int TICK_DIV   = 16;
  localparam int MAX_ON     = 8;
  localparam int SOAK       = 4;
  localparam int MAX_ACTIVE = 2;
  localparam int CH_W       = 3;
  localparam int CNT_W      = 3;
  localparam int W          = 2 * N_CH + CNT_W;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             sample_valid = 1'b0;
  logic [CH_W-1:0]  sample_ch = '0;
  logic [DW-1:0]    sample_data = '0;
  logic [DW-1:0]    low_thr = 8'd60;
  logic [DW-1:0]    high_thr = 8'd120;
  logic             fault_clr = 1'b0;
  logic [N_CH-1:0]  valve;
  logic [N_CH-1:0]  fault;
  logic [CNT_W-1:0] active_cnt;

  always #5 clk = ~clk;

  irrigation_scheduler #(
    .N_CH         (N_CH),
    .DW           (DW),
    .TICK_DIV     (TICK_DIV),
    .MAX_ON_TICKS (MAX_ON),
    .SOAK_TICKS   (SOAK),
    .MAX_ACTIVE   (MAX_ACTIVE),
    .CH_W         (CH_W),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .low_thr      (low_thr),
    .high_thr     (high_thr),
    .fault_clr    (fault_clr),
    .valve        (valve),
    .fault        (fault),
    .active_cnt   (active_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // Each channel is in phase 0 (closed), 1 (watering) or 2 (soaking) and
  // counts the timer ticks seen since it entered that phase.
  int   m_phase [N_CH];
  int   m_ticks [N_CH];
  bit   m_fault [N_CH];
  int   m_moist [N_CH];
  int   m_cyc;
  int   n_phase [N_CH];
  int   n_ticks [N_CH];
  bit   n_fault [N_CH];
  int   kept;
  int   free_slots;
  bit   tick_now;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_cur;

  function automatic logic [W-1:0] model_outputs();
    logic [N_CH-1:0]  v;
    logic [N_CH-1:0]  f;
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) begin
      v[i] = (m_phase[i] == 1);
      f[i] = m_fault[i];
      if (m_phase[i] == 1) c = c + 1'b1;
    end
    return {c, f, v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        m_phase[i] = 0;
        m_ticks[i] = 0;
        m_fault[i] = 0;
        m_moist[i] = 255;
      end
      m_cyc = 0;
      exp_q.delete();
      exp_q.push_back(model_outputs());
    end else begin
      tick_now = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      kept = 0;
      for (int i = 0; i < N_CH; i++) begin
        n_phase[i] = m_phase[i];
        n_ticks[i] = m_ticks[i];
        n_fault[i] = fault_clr ? 1'b0 : m_fault[i];
        if (!ena) begin
          n_phase[i] = 0;
          n_ticks[i] = 0;
        end else if (m_phase[i] == 1) begin
          if (tick_now && (m_ticks[i] + 1 == MAX_ON)) begin
            n_phase[i] = 2;
            n_ticks[i] = 0;
            n_fault[i] = 1;
          end else if (m_moist[i] >= int'(high_thr)) begin
            n_phase[i] = 2;
            n_ticks[i] = 0;
          end else begin
            if (tick_now) n_ticks[i] = m_ticks[i] + 1;
            kept++;
          end
        end else if (m_phase[i] == 2) begin
          if (tick_now) begin
            n_ticks[i] = m_ticks[i] + 1;
            if (n_ticks[i] == SOAK) begin
              n_phase[i] = 0;
              n_ticks[i] = 0;
            end
          end
        end
      end
      free_slots = MAX_ACTIVE - kept;
      for (int i = 0; i < N_CH; i++) begin
        if (ena && m_phase[i] == 0 && m_moist[i] < int'(low_thr) &&
            !m_fault[i] && free_slots > 0) begin
          n_phase[i] = 1;
          n_ticks[i] = 0;
          free_slots--;
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        m_phase[i] = n_phase[i];
        m_ticks[i] = n_ticks[i];
        m_fault[i] = n_fault[i];
      end
      if (sample_valid && int'(sample_ch) < N_CH) m_moist[sample_ch] = int'(sample_data);
      m_cyc++;
      exp_q.push_back(model_outputs());
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty t=%0t no expected entry", $time);
    end else begin
      e_cur = exp_q.pop_front();
      n_vec++;
      if (valve !== e_cur[N_CH-1:0]) begin
        n_err++;
        $display("FAIL sb_valve t=%0t got %b exp %b", $time, valve, e_cur[N_CH-1:0]);
      end
      n_vec++;
      if (fault !== e_cur[2*N_CH-1:N_CH]) begin
        n_err++;
        $display("FAIL sb_fault t=%0t got %b exp %b", $time, fault, e_cur[2*N_CH-1:N_CH]);
      end
      n_vec++;
      if (active_cnt !== e_cur[W-1:2*N_CH]) begin
        n_err++;
        $display("FAIL sb_cnt t=%0t got %0d exp %0d", $time, active_cnt, e_cur[W-1:2*N_CH]);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d exp %0d", name, $time, act, exp);
    end
  endtask

  task automatic send(input int ch, input int data);
    sample_valid = 1'b1;
    sample_ch    = CH_W'(ch);
    sample_data  = DW'(data);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_valve(input int ch, input logic lvl, input int max_cyc, output int n);
    n = 0;
    while (valve[ch] !== lvl && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [N_CH-1:0] dry;

    idle_cycles(3);
    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);
    chk("reset_valve", 32'(valve), 0);
    chk("reset_fault", 32'(fault), 0);
    chk("reset_cnt", 32'(active_cnt), 0);

    // Hysteresis on ch1
    send(1, 50);
    chk("hyst_not_yet", 32'(valve[1]), 0);
    @(negedge clk);
    chk("hyst_open", 32'(valve[1]), 1);
    send(1, 100);
    idle_cycles(3);
    chk("hyst_hold", 32'(valve[1]), 1);
    send(1, 120);
    @(negedge clk);
    chk("hyst_close", 32'(valve[1]), 0);
    send(1, 40);
    wait_valve(1, 1'b1, 100, n);
    chk("soak_reopen_window", 32'(n >= 49 && n <= 64), 1);
    send(1, 200);
    idle_cycles(70);

    // Concurrency cap
    for (int c = 0; c < 4; c++) send(c, 10);
    idle_cycles(2);
    chk("cap_valves", 32'(valve), 32'b00011);
    chk("cap_cnt", 32'(active_cnt), 2);
    send(0, 200);
    @(negedge clk);
    chk("handover_valves", 32'(valve), 32'b00110);
    chk("handover_cnt", 32'(active_cnt), 2);
    send(3, 200);
    send(1, 200);
    send(2, 200);
    idle_cycles(70);

    // Timeout with fault_clr held: the timeout edge must still set fault
    fault_clr = 1'b1;
    send(2, 30);
    wait_valve(2, 1'b1, 10, n);
    chk("to_open", 32'(valve[2]), 1);
    wait_valve(2, 1'b0, 200, n);
    chk("to_duration", 32'(n >= 113 && n <= 128), 1);
    chk("to_fault_over_clr", 32'(fault[2]), 1);
    fault_clr = 1'b0;
    idle_cycles(80);
    chk("fault_blocks_valve", 32'(valve[2]), 0);
    chk("fault_sticky", 32'(fault[2]), 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("fault_cleared", 32'(fault[2]), 0);
    wait_valve(2, 1'b1, 5, n);
    chk("fault_reopen", 32'(valve[2]), 1);
    send(2, 200);
    idle_cycles(70);

    // Out-of-range channel indices are dropped
    send(5, 0);
    send(7, 0);
    idle_cycles(4);
    chk("oob_valves", 32'(valve), 0);
    chk("oob_cnt", 32'(active_cnt), 0);

    // ena low closes everything on the next edge
    send(0, 10);
    send(3, 10);
    @(negedge clk);
    chk("ena_two_open", 32'(valve), 32'b01001);
    ena = 1'b0;
    @(negedge clk);
    chk("ena_off_valves", 32'(valve), 0);
    chk("ena_off_cnt", 32'(active_cnt), 0);
    ena = 1'b1;
    idle_cycles(3);
    send(0, 200);
    send(3, 200);
    idle_cycles(70);

    // Asynchronous reset in the middle of watering
    send(4, 10);
    idle_cycles(3);
    chk("pre_reset_open", 32'(valve[4]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valve", 32'(valve), 0);
    chk("async_rst_fault", 32'(fault), 0);
    chk("async_rst_cnt", 32'(active_cnt), 0);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(10);
    chk("no_water_after_rst", 32'(valve), 0);

    // Randomized traffic against the model
    dry = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 500 == 0) dry = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      if (cyc % 700 == 350) begin
        low_thr  = DW'($urandom_range(20, 120));
        high_thr = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, int'(low_thr)))
                                               : DW'($urandom_range(int'(low_thr) + 1, 250));
      end
      sample_valid = ($urandom_range(0, 2) != 0);
      sample_ch    = CH_W'($urandom_range(0, 7));
      if (int'(sample_ch) < N_CH && dry[sample_ch])
        sample_data = DW'($urandom_range(0, 19));
      else
        sample_data = DW'($urandom_range(0, 255));
      ena       = ($urandom_range(0, 63) != 0);
      fault_clr = ($urandom_range(0, 99) == 0);
      if (cyc == 2000) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    sample_valid = 1'b0;
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Multi-channel irrigation controller for the precision-farming ASIC.
- Takes time-multiplexed soil-moisture samples, keeps the latest value per channel, and drives one valve per channel through a hysteresis state machine (IDLE -> WATER -> SOAK).
- Enforces a maximum watering time with a sticky fault per channel, and caps how many valves may be open at once.
- Sits between the sensor ADC sequencer and the uo_out valve drivers. It is the parametrised N-channel successor of the single-zone top-level logic.

Parameters:
- N_CH, 4: number of irrigation channels/valves (1..16).
- DW, 8: moisture sample and threshold width.
- TICK_DIV, 16: clk cycles per timer tick (>=2).
- MAX_ON_TICKS, 8: watering timeout in ticks (>=1).
- SOAK_TICKS, 4: post-watering lockout in ticks (>=1).
- MAX_ACTIVE, 2: maximum channels in WATER at once (1..N_CH).
- CH_W, $clog2(N_CH) (min 1): channel index width (derived).
- CNT_W, $clog2(N_CH+1): active-count width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable. Low forces all channels to IDLE.
- sample_valid  in  1  sample strobe.
- sample_ch  in  CH_W  channel index of the sample.
- sample_data  in  DW  moisture value (higher = wetter).
- low_thr  in  DW  start watering when moisture < low_thr.
- high_thr  in  DW  stop watering when moisture >= high_thr.
- fault_clr  in  1  clears all fault flags.
- valve  out  N_CH  valve drive, 1 = open.
- fault  out  N_CH  sticky timeout flag per channel.
- active_cnt  out  CNT_W  number of channels currently in WATER.

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - moist[] = all ones.
  - All channel FSMs in IDLE, all timers 0, prescaler 0.
  - valve = 0, fault = 0, active_cnt = 0.
- Sample capture: on an edge with sample_valid=1 and sample_ch < N_CH, moist[sample_ch] <= sample_data. Samples with sample_ch >= N_CH are ignored.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = (prescaler == TICK_DIV-1). It runs regardless of ena.
- Per-channel FSM, evaluated every edge from the registered moist[]:
  - IDLE -> WATER when ena=1, moist < low_thr, fault=0 and a start grant is given. The timer clears on entry.
  - WATER -> SOAK when moist >= high_thr (normal stop), timer clears.
  - WATER -> SOAK when tick arrives with timer == MAX_ON_TICKS-1 (timeout). This also sets fault. The timer clears.
  - If both stop conditions hold on the same edge, the timeout wins and fault is set.
  - Otherwise the timer increments on each tick while in WATER.
  - SOAK -> IDLE when tick arrives with timer == SOAK_TICKS-1. Otherwise the timer increments on tick. Moisture is ignored in SOAK.
- Outputs:
  - valve[i] = (state == WATER). Registered, Moore.
  - Latency: sample edge k, state change edge k+1, so valve changes visibly after edge k+1.
  - active_cnt is the registered count of WATER states.
- Start arbitration:
  - slots = MAX_ACTIVE - (count of channels currently in WATER that are not leaving it this edge).
  - Requesting IDLE channels are granted in ascending index order until slots are exhausted.
  - Denied channels stay IDLE and re-request on later edges; no request is queued.
- Fault:
  - A channel with fault set cannot leave IDLE.
  - fault_clr clears all flags on the next edge. A fault set on the same edge wins over fault_clr.
- ena low: every FSM goes to IDLE on the next edge and all timers clear. fault and moist[] are retained. valve = 0 after that edge.
- Threshold misconfiguration (high_thr <= low_thr) is legal. Watering lasts one cycle, then SOAK.
- Watering duration on timeout lies between (MAX_ON_TICKS-1)*TICK_DIV+1 and MAX_ON_TICKS*TICK_DIV cycles.

Decomposition:
- Package irr_pkg:
  - ch_state_e enum {IDLE, WATER, SOAK}, 2 bits.
  - Default-parameter constants.
  - Function popcount.
- Sub-module irr_channel_fsm: one instance per channel via generate. Inputs are moisture, thresholds, tick, grant, ena, fault_clr. Outputs are state, request, fault.
- Parent module holds the moist[] array, prescaler, arbiter and active_cnt.

Test Plan (defaults; low_thr=60, high_thr=120):
- Reset/idle: assert rst_n=0 mid-WATER -> valve=0, fault=0, active_cnt=0 immediately. No watering after release without new samples.
- Hysteresis: ch1 sample 50 -> valve[1]=1 two edges after the sample. Samples 100 -> valve stays 1. Sample 120 -> valve[1]=0 next edge. Sample 40 during SOAK -> no reopen for 4 ticks; then reopens.
- Concurrency: samples 10 on ch0..ch3 in four consecutive cycles -> only valve[0] and valve[1] open, active_cnt=2. ch0 reaches 200 -> ch2 opens no later than one edge after ch0 closes.
- Timeout: ch2 held at 30 -> valve[2] drops and fault[2]=1 within 113..128 cycles of opening. The channel stays closed after SOAK. fault_clr pulse -> reopens.
- Boundaries: sample_ch=5 is ignored (all moist unchanged). fault_clr on the same edge as a timeout -> fault stays 1. ena=0 while two valves are open -> both 0 next edge, active_cnt=0.
